// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: sequencer state encoding and default counter width.
package fft_pkg;

  localparam int unsigned FFT_CYCLE_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } fft_state_e;

endpackage

// File: rtl/fft_sequencer.sv
// FFT run sequencer: arms the core, times the RUN phase, waits for write-back
// to go quiet, then reports completion, timeout error or config error.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned CYCLE_W      = FFT_CYCLE_W,
  parameter int unsigned MAX_CFG      = 4,
  parameter int unsigned TIMEOUT      = 2000,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_start,
  input  logic [2:0]         i_point_config,
  input  logic               i_abort,
  input  logic               i_clear,
  input  logic               i_fft_done,
  input  logic               i_write_enable,
  output logic               o_working,
  output logic [CYCLE_W-1:0] o_cycle_count,
  output logic [2:0]         o_point_config,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_cfg_err,
  output logic               o_error,
  output logic [CYCLE_W-1:0] o_run_cycles
);

  localparam int unsigned          DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CYCLE_W-1:0]   CC_LAST    = CYCLE_W'(TIMEOUT - 1);
  localparam logic [CYCLE_W-1:0]   CC_MAX     = '1;
  localparam logic [DRAIN_W-1:0]   DRAIN_DONE = DRAIN_W'(DRAIN_CYCLES);

  fft_state_e         r_state;
  logic               r_working;
  logic [CYCLE_W-1:0] r_cycle_count;
  logic [2:0]         r_point_config;
  logic               r_busy;
  logic               r_done;
  logic               r_cfg_err;
  logic               r_error;
  logic [CYCLE_W-1:0] r_run_cycles;
  logic [DRAIN_W-1:0] r_drain_cnt;

  logic               w_cfg_ok;
  logic [CYCLE_W-1:0] w_cc_inc;
  logic [DRAIN_W-1:0] w_drain_nxt;

  always_comb begin
    w_cfg_ok    = (i_point_config <= 3'(MAX_CFG));
    w_cc_inc    = (r_cycle_count == CC_MAX) ? r_cycle_count : r_cycle_count + CYCLE_W'(1);
    w_drain_nxt = i_write_enable ? '0 : r_drain_cnt + DRAIN_W'(1);
  end

  // Every flag is registered alongside the state it belongs to, so o_busy and
  // o_working always agree with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= ST_IDLE;
      r_working      <= 1'b0;
      r_cycle_count  <= '0;
      r_point_config <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_error        <= 1'b0;
      r_run_cycles   <= '0;
      r_drain_cnt    <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_clear) r_error <= 1'b0;
          if (i_start && !r_error) begin
            if (w_cfg_ok) begin
              r_point_config <= i_point_config;
              r_state        <= ST_ARM;
              r_busy         <= 1'b1;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cycle_count <= '0;
            r_state       <= ST_RUN;
            r_working     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_working <= 1'b0;
          end else if (i_fft_done) begin
            r_run_cycles <= w_cc_inc;
            r_drain_cnt  <= '0;
            r_state      <= ST_DRAIN;
            r_working    <= 1'b0;
          end else if (r_cycle_count == CC_LAST) begin
            r_state   <= ST_ERROR;
            r_working <= 1'b0;
            r_error   <= 1'b1;
          end else begin
            r_cycle_count <= w_cc_inc;
          end
        end
        ST_DRAIN: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_drain_cnt <= w_drain_nxt;
            if (w_drain_nxt == DRAIN_DONE) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_working <= 1'b0;
        end
      endcase
    end
  end

  assign o_working      = r_working;
  assign o_cycle_count  = r_cycle_count;
  assign o_point_config = r_point_config;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_cfg_err      = r_cfg_err;
  assign o_error        = r_error;
  assign o_run_cycles   = r_run_cycles;

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed self-checking bench for fft_sequencer with default parameters.
module tb_fft_sequencer;

  localparam int unsigned CW = 11;

  logic          clk;
  logic          rstn;
  logic          i_start;
  logic [2:0]    i_point_config;
  logic          i_abort;
  logic          i_clear;
  logic          i_fft_done;
  logic          i_write_enable;
  logic          o_working;
  logic [CW-1:0] o_cycle_count;
  logic [2:0]    o_point_config;
  logic          o_busy;
  logic          o_done;
  logic          o_cfg_err;
  logic          o_error;
  logic [CW-1:0] o_run_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int n_work   = 0;

  fft_sequencer #(
    .CYCLE_W      (CW),
    .MAX_CFG      (4),
    .TIMEOUT      (2000),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_start        (i_start),
    .i_point_config (i_point_config),
    .i_abort        (i_abort),
    .i_clear        (i_clear),
    .i_fft_done     (i_fft_done),
    .i_write_enable (i_write_enable),
    .o_working      (o_working),
    .o_cycle_count  (o_cycle_count),
    .o_point_config (o_point_config),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_cfg_err      (o_cfg_err),
    .o_error        (o_error),
    .o_run_cycles   (o_run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic pat [7];
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rstn = 1'b0; i_start = 1'b0; i_point_config = '0; i_abort = 1'b0;
    i_clear = 1'b0; i_fft_done = 1'b0; i_write_enable = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_working", 32'(o_working), 0);
    chk("rst_cc", 32'(o_cycle_count), 0);
    chk("rst_pc", 32'(o_point_config), 0);
    chk("rst_run", 32'(o_run_cycles), 0);
    chk("rst_flags", {29'd0, o_done, o_cfg_err, o_error}, 0);
    rstn = 1'b1;
    tick();

    // Normal run: done at RUN cycle 99, quiet write-back
    i_start = 1'b1; i_point_config = 3'd2;
    tick();
    i_start = 1'b0;
    chk("arm_busy", 32'(o_busy), 1);
    chk("arm_pc", 32'(o_point_config), 2);
    chk("arm_working", 32'(o_working), 0);
    tick();
    chk("run0_cc", 32'(o_cycle_count), 0);
    for (int n = 0; n < 100; n++) begin
      if (o_working) n_work++;
      if (n == 50) chk("run50_cc", 32'(o_cycle_count), 50);
      if (n == 99) begin
        chk("run99_cc", 32'(o_cycle_count), 99);
        i_fft_done = 1'b1;
      end
      tick();
    end
    i_fft_done = 1'b0;
    chk("work_cycles", 32'(n_work), 100);
    chk("drain_working", 32'(o_working), 0);
    chk("run_cycles", 32'(o_run_cycles), 100);
    chk("drain_busy", 32'(o_busy), 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("drain_nodone", 32'(o_done), 0);
    end
    tick();
    chk("done_pulse", 32'(o_done), 1);
    chk("done_busy", 32'(o_busy), 1);
    tick();
    chk("done_end", 32'(o_done), 0);
    chk("idle_busy", 32'(o_busy), 0);
    chk("cc_held", 32'(o_cycle_count), 99);

    // Illegal config
    i_start = 1'b1; i_point_config = 3'd6;
    tick();
    i_start = 1'b0;
    chk("cfgerr_pulse", 32'(o_cfg_err), 1);
    chk("cfgerr_busy", 32'(o_busy), 0);
    chk("cfgerr_pc", 32'(o_point_config), 2);
    tick();
    chk("cfgerr_end", 32'(o_cfg_err), 0);
    chk("cfgerr_busy2", 32'(o_busy), 0);

    // Drain with a write-back burst in the middle
    i_start = 1'b1; i_point_config = 3'd1;
    tick();
    i_start = 1'b0;
    tick();
    i_fft_done = 1'b1;
    tick();
    i_fft_done = 1'b0;
    chk("short_run", 32'(o_run_cycles), 1);
    for (int k = 0; k < 7; k++) begin
      i_write_enable = pat[k];
      chk("pat_nodone", 32'(o_done), 0);
      tick();
    end
    i_write_enable = 1'b0;
    chk("pat_done", 32'(o_done), 1);
    tick();
    chk("pat_idle", 32'(o_busy), 0);

    // Abort coincident with done
    i_start = 1'b1; i_point_config = 3'd3;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("abort_pre", 32'(o_working), 1);
    i_abort = 1'b1; i_fft_done = 1'b1;
    tick();
    i_abort = 1'b0; i_fft_done = 1'b0;
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_working", 32'(o_working), 0);
    chk("abort_run", 32'(o_run_cycles), 1);
    chk("abort_flags", {30'd0, o_done, o_error}, 0);
    tick();
    chk("abort_nodone", 32'(o_done), 0);

    // Timeout
    i_start = 1'b1; i_point_config = 3'd0;
    tick();
    i_start = 1'b0;
    tick();
    for (int k = 0; k < 1999; k++) tick();
    chk("to_working", 32'(o_working), 1);
    chk("to_cc", 32'(o_cycle_count), 1999);
    tick();
    chk("to_error", 32'(o_error), 1);
    chk("to_working_off", 32'(o_working), 0);
    chk("to_busy", 32'(o_busy), 1);
    tick();
    chk("to_idle", 32'(o_busy), 0);
    chk("to_sticky", 32'(o_error), 1);
    i_start = 1'b1; i_point_config = 3'd1;
    tick();
    chk("err_ignore_busy", 32'(o_busy), 0);
    chk("err_ignore_pc", 32'(o_point_config), 0);
    i_point_config = 3'd7;
    tick();
    chk("err_ignore_cfgerr", 32'(o_cfg_err), 0);
    i_start = 1'b0; i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk("clear_error", 32'(o_error), 0);
    chk("clear_run", 32'(o_run_cycles), 1);

    // Reset in the middle of RUN
    i_start = 1'b1; i_point_config = 3'd4;
    tick();
    i_start = 1'b0;
    tick();
    for (int k = 0; k < 50; k++) tick();
    chk("mid_cc", 32'(o_cycle_count), 50);
    chk("mid_pc", 32'(o_point_config), 4);
    #2 rstn = 1'b0;
    #1;
    chk("async_working", 32'(o_working), 0);
    chk("async_busy", 32'(o_busy), 0);
    chk("async_cc", 32'(o_cycle_count), 0);
    chk("async_pc", 32'(o_point_config), 0);
    chk("async_run", 32'(o_run_cycles), 0);
    tick();
    rstn = 1'b1;
    tick(); tick();
    chk("no_resume", 32'(o_busy), 0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("restart_busy", 32'(o_busy), 1);
    chk("restart_pc", 32'(o_point_config), 4);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("arm_abort", 32'(o_busy), 0);
    chk("arm_abort_work", 32'(o_working), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_sequencer.md
FFT_SEQUENCER -- requirements
Module: fft_sequencer

Interface
REQ-001 SHALL have parameter CYCLE_W, default 11, width of the cycle counter.
REQ-002 SHALL have parameter MAX_CFG, default 4, highest legal point-configuration code.
REQ-003 SHALL have parameter TIMEOUT, default 2000, RUN cycle limit before abort-to-error.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 4, consecutive write-idle cycles required to finish.
REQ-005 SHALL have ports: clk input 1, the single clock; rstn input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: i_start input 1, start request; i_point_config input 3, requested configuration; i_abort input 1, cancel; i_clear input 1, clears error.
REQ-007 SHALL have ports: i_fft_done input 1, done from the FFT core; i_write_enable input 1, FFT core write-back strobe.
REQ-008 SHALL have ports: o_working output 1; o_cycle_count output CYCLE_W; o_point_config output 3 (these three drive the FFT core).
REQ-009 SHALL have ports: o_busy output 1; o_done output 1, one-cycle pulse; o_cfg_err output 1, one-cycle pulse; o_error output 1, sticky; o_run_cycles output CYCLE_W, last RUN length.

Function
REQ-010 SHALL implement states IDLE, ARM, RUN, DRAIN, DONE, ERROR; o_busy SHALL be 1 in every state except IDLE.
REQ-011 SHALL, in IDLE with i_start=1 and i_point_config<=MAX_CFG and o_error=0, latch the config into o_point_config and go to ARM.
REQ-012 SHALL, in IDLE with i_start=1 and i_point_config>MAX_CFG, pulse o_cfg_err for one cycle and stay IDLE; o_point_config unchanged.
REQ-013 SHALL ignore i_start outside IDLE and while o_error=1.
REQ-014 SHALL, in ARM (one cycle), clear o_cycle_count to 0 and go to RUN; o_working=0 in ARM.
REQ-015 SHALL drive o_working=1 exactly while in RUN; o_cycle_count=0 in first RUN cycle, +1 each following cycle, saturating at 2^CYCLE_W-1.
REQ-016 SHALL, in RUN with i_fft_done=1, capture o_cycle_count+1 into o_run_cycles and go to DRAIN next cycle.
REQ-017 SHALL, in RUN when o_cycle_count equals TIMEOUT-1 and i_fft_done=0, go to ERROR; i_fft_done wins on the same cycle.
REQ-018 SHALL, in DRAIN, count consecutive cycles with i_write_enable=0, resetting the count to 0 on any cycle with i_write_enable=1, and go to DONE when the count reaches DRAIN_CYCLES.
REQ-019 SHALL, in DONE (one cycle), assert o_done and return to IDLE.
REQ-020 SHALL, in ERROR, set o_error=1 and go to IDLE next cycle; o_error SHALL stay 1 until i_clear=1 in IDLE.
REQ-021 SHALL, on i_abort=1 in ARM, RUN or DRAIN, go to IDLE next cycle without o_done or o_error; i_abort has priority over i_fft_done and timeout.
REQ-022 SHALL hold o_point_config and o_cycle_count stable outside RUN (o_cycle_count retains its last value).
REQ-023 SHALL register all outputs; no combinational input-to-output path.

Reset
REQ-024 SHALL, on rstn=0, asynchronously enter IDLE with o_working=0, o_cycle_count=0, o_point_config=0, o_busy=0, o_done=0, o_cfg_err=0, o_error=0, o_run_cycles=0, drain counter=0.
REQ-025 SHALL, on reset mid-run, drop o_working immediately and resume only on a new i_start after rstn=1.

Structure
REQ-026 SHALL take the state enum and the CYCLE_W default from a shared package fft_pkg used by the FFT datapath blocks.
REQ-027 SHALL be a single module with no sub-modules; the drain counter SHALL be a local counter of width $clog2(DRAIN_CYCLES+1).

Verification
REQ-028 Start cfg=2, i_fft_done at RUN cycle 99, write_enable low after -> o_run_cycles=100, o_done one cycle 4 cycles after DRAIN entry +1, o_working high exactly 100 cycles.
REQ-029 Start cfg=6 -> o_cfg_err one pulse, o_busy stays 0, o_point_config unchanged.
REQ-030 Start, never assert i_fft_done -> ERROR after 2000 RUN cycles, o_error=1, later i_start ignored until i_clear.
REQ-031 DRAIN with i_write_enable pattern 0,0,1,0,0,0,0 -> o_done only after the final four zeros.
REQ-032 i_abort in RUN coincident with i_fft_done -> IDLE, no o_done, o_run_cycles unchanged.
REQ-033 rstn low at RUN cycle 50 -> o_working=0 same cycle, all outputs at reset values.
